// File: rtl/led_stream_receiver_pkg.sv
// Shared constants and types for the LED strip stream receiver.
//  LED_START_WORD / LED_END_WORD : frame delimiters on the wire
//  LED_HDR                       : top three bits of every LED word
//  LedWord                       : brightness + colour payload of an LED word
//  rx_state_t                    : receiver FSM states
package led_stream_receiver_pkg;

  localparam logic [31:0] LED_START_WORD = 32'h0000_0000;
  localparam logic [31:0] LED_END_WORD   = 32'hFFFF_FFFF;
  localparam logic [2:0]  LED_HDR        = 3'b111;

  typedef struct packed {
    logic [4:0]  bright;
    logic [23:0] rgb;
  } LedWord;

  typedef enum logic {
    HUNT = 1'b0,
    WORD = 1'b1
  } rx_state_t;

  function automatic logic is_led_hdr(input logic [2:0] hdr);
    return hdr == LED_HDR;
  endfunction

endpackage

// File: rtl/led_stream_receiver_if.sv
// Decoded-record bundle produced by led_stream_receiver.
//  led_valid  : 1-cycle pulse, led_* fields valid (fields hold until next pulse)
//  led_idx    : LED position within the current frame
//  led_bright : global-brightness field
//  led_rgb    : colour bits in wire order
//  frame_done : 1-cycle pulse on a valid end frame
//  led_count  : LEDs received in the last completed frame (held)
//  frame_err  : 1-cycle pulse on bad header, overflow or timeout
// master = receiver side, slave = consumer side.
interface led_stream_receiver_if #(
  parameter int LEDS = 50
) ();

  logic                      led_valid;
  logic [$clog2(LEDS)-1:0]   led_idx;
  logic [4:0]                led_bright;
  logic [23:0]               led_rgb;
  logic                      frame_done;
  logic [$clog2(LEDS+1)-1:0] led_count;
  logic                      frame_err;

  modport master (
    output led_valid, led_idx, led_bright, led_rgb, frame_done, led_count, frame_err
  );

  modport slave (
    input led_valid, led_idx, led_bright, led_rgb, frame_done, led_count, frame_err
  );

endinterface

// File: rtl/led_stream_receiver_edge_sync.sv
// Brings the strip clock and data into the clk domain.
//  clk, rst : system clock, asynchronous active-high reset
//  clk_in   : strip clock (asynchronous)
//  d_in     : strip data (asynchronous, stable around clk_in rising edge)
//  rise     : 1-cycle pulse on a synchronized clk_in rising edge
//  d_sync   : synchronized data, valid to sample while rise is high
// Both inputs go through identical chains so data keeps its alignment to
// the clock edge it was launched against.
module led_stream_receiver_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_in,
  input  logic d_in,
  output logic rise,
  output logic d_sync
);

  logic [SYNC_STAGES-1:0] clk_sync_reg;
  logic [SYNC_STAGES-1:0] d_sync_reg;
  logic                   prev_clk_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_reg <= '0;
      d_sync_reg   <= '0;
      prev_clk_reg <= 1'b0;
    end else begin
      clk_sync_reg <= {clk_sync_reg[SYNC_STAGES-2:0], clk_in};
      d_sync_reg   <= {d_sync_reg[SYNC_STAGES-2:0], d_in};
      prev_clk_reg <= clk_sync_reg[SYNC_STAGES-1];
    end
  end

  assign rise   = clk_sync_reg[SYNC_STAGES-1] & ~prev_clk_reg;
  assign d_sync = d_sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/led_stream_receiver.sv
// Receive end of the two-wire (clock + data) LED strip protocol.
//  clk, rst : system clock, asynchronous active-high reset
//  clkIn    : strip clock, asynchronous, period >= 4 clk cycles
//  dIn      : strip data, MSB first, sampled on clkIn rising edge
//  rec      : decoded record outputs (see led_stream_receiver_if)
// Frames are a 32-bit start word of zeros, LED words {111, bright, rgb},
// then a 32-bit end word of ones. HUNT waits for 32 consecutive zeros,
// WORD assembles and decodes 32-bit words.
module led_stream_receiver
  import led_stream_receiver_pkg::*;
#(
  parameter int LEDS        = 50,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clkIn,
  input  logic dIn,
  led_stream_receiver_if.master rec
);

  localparam int IDX_W = $clog2(LEDS);
  localparam int CNT_W = $clog2(LEDS + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  logic rise;
  logic d_s;

  led_stream_receiver_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk    (clk),
    .rst    (rst),
    .clk_in (clkIn),
    .d_in   (dIn),
    .rise   (rise),
    .d_sync (d_s)
  );

  rx_state_t        state_reg;
  logic [30:0]      shift_reg;
  logic [4:0]       bitcnt_reg;
  logic [5:0]       zero_cnt_reg;
  logic [CNT_W-1:0] idx_reg;
  logic [TO_W-1:0]  to_cnt_reg;

  logic             led_valid_reg;
  logic [IDX_W-1:0] led_idx_reg;
  logic [4:0]       led_bright_reg;
  logic [23:0]      led_rgb_reg;
  logic             frame_done_reg;
  logic [CNT_W-1:0] led_count_reg;
  logic             frame_err_reg;

  // The word including the bit arriving this cycle; decoding it directly
  // lets led_valid appear one clk after the 32nd rise.
  logic [31:0] word_next;
  LedWord      led_word;

  assign word_next = {shift_reg, d_s};
  assign led_word  = word_next[28:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= HUNT;
      shift_reg      <= '0;
      bitcnt_reg     <= '0;
      zero_cnt_reg   <= '0;
      idx_reg        <= '0;
      to_cnt_reg     <= '0;
      led_valid_reg  <= 1'b0;
      led_idx_reg    <= '0;
      led_bright_reg <= '0;
      led_rgb_reg    <= '0;
      frame_done_reg <= 1'b0;
      led_count_reg  <= '0;
      frame_err_reg  <= 1'b0;
    end else begin
      led_valid_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
      frame_err_reg  <= 1'b0;

      case (state_reg)
        HUNT: begin
          to_cnt_reg <= '0;
          if (rise) begin
            // Any 1 (including surplus end-frame ones) restarts the zero run.
            if (d_s) begin
              zero_cnt_reg <= '0;
            end else if (zero_cnt_reg == 6'd31) begin
              state_reg    <= WORD;
              zero_cnt_reg <= '0;
              idx_reg      <= '0;
              bitcnt_reg   <= '0;
            end else begin
              zero_cnt_reg <= zero_cnt_reg + 6'd1;
            end
          end
        end

        WORD: begin
          if (rise) begin
            to_cnt_reg <= '0;
            shift_reg  <= word_next[30:0];
            bitcnt_reg <= bitcnt_reg + 5'd1;  // wraps 31 -> 0 on completion
            if (bitcnt_reg == 5'd31) begin
              if (word_next == LED_END_WORD) begin
                frame_done_reg <= 1'b1;
                led_count_reg  <= idx_reg;
                state_reg      <= HUNT;
              end else if (word_next == LED_START_WORD) begin
                idx_reg <= '0;
              end else if (is_led_hdr(word_next[31:29])) begin
                if (idx_reg < CNT_W'(LEDS)) begin
                  led_valid_reg  <= 1'b1;
                  led_idx_reg    <= idx_reg[IDX_W-1:0];
                  led_bright_reg <= led_word.bright;
                  led_rgb_reg    <= led_word.rgb;
                  idx_reg        <= idx_reg + CNT_W'(1);
                end else begin
                  // Overflow: drop the word, idx stays saturated at LEDS.
                  frame_err_reg <= 1'b1;
                end
              end else begin
                frame_err_reg <= 1'b1;
                state_reg     <= HUNT;
              end
            end
          end else if (to_cnt_reg == TO_W'(TIMEOUT - 1)) begin
            frame_err_reg <= 1'b1;
            state_reg     <= HUNT;
            to_cnt_reg    <= '0;
          end else begin
            to_cnt_reg <= to_cnt_reg + TO_W'(1);
          end
        end

        default: state_reg <= HUNT;
      endcase
    end
  end

  assign rec.led_valid  = led_valid_reg;
  assign rec.led_idx    = led_idx_reg;
  assign rec.led_bright = led_bright_reg;
  assign rec.led_rgb    = led_rgb_reg;
  assign rec.frame_done = frame_done_reg;
  assign rec.led_count  = led_count_reg;
  assign rec.frame_err  = frame_err_reg;

endmodule

// File: tb/tb_led_stream_receiver.sv
// Scoreboard bench for led_stream_receiver: stimulus pushes expected
// records into a queue; a monitor pops and compares on every output pulse.
module tb_led_stream_receiver;

  localparam int LEDS        = 3;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 64;

  localparam int K_LED  = 0;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;

  typedef struct {
    int kind;
    int idx;
    int bright;
    int rgb;
    int count;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clkIn = 1'b0;
  logic dIn = 1'b0;

  int total = 0;
  int bad   = 0;
  exp_t exp_q[$];

  led_stream_receiver_if #(.LEDS(LEDS)) rec ();

  led_stream_receiver #(
    .LEDS        (LEDS),
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .clkIn (clkIn),
    .dIn   (dIn),
    .rec   (rec)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pop_and_check(input int kind);
    exp_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: got kind %0d expected none", kind);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      if (kind == K_LED && e.kind == K_LED) begin
        check("led_idx", 32'(rec.led_idx), e.idx);
        check("led_bright", 32'(rec.led_bright), e.bright);
        check("led_rgb", 32'(rec.led_rgb), e.rgb);
        $display("led   idx=%0d bright=%0h rgb=%06h", rec.led_idx, rec.led_bright, rec.led_rgb);
      end else if (kind == K_DONE && e.kind == K_DONE) begin
        check("led_count", 32'(rec.led_count), e.count);
        $display("done  led_count=%0d", rec.led_count);
      end else if (kind == K_ERR) begin
        $display("err   frame_err pulse");
      end
    end
  endtask

  // Monitor: sampled on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (rec.led_valid && rec.frame_err) check("valid_err_overlap", 1, 0);
    if (rec.led_valid)  pop_and_check(K_LED);
    if (rec.frame_done) pop_and_check(K_DONE);
    if (rec.frame_err)  pop_and_check(K_ERR);
  end

  function automatic exp_t mk(input int kind, input int idx, input int bright,
                              input int rgb, input int count);
    exp_t e;
    e.kind = kind; e.idx = idx; e.bright = bright; e.rgb = rgb; e.count = count;
    return e;
  endfunction

  task automatic send_bit(input logic b);
    clkIn = 1'b0;
    dIn   = b;
    repeat (4) @(negedge clk);
    clkIn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Sends the top n bits of w, MSB first.
  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = 31; i > 31 - n; i--) send_bit(w[i]);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_bits(w, 32);
  endtask

  task automatic send_led(input int idx, input logic [4:0] bright, input logic [23:0] rgb);
    exp_q.push_back(mk(K_LED, idx, int'(bright), int'(rgb), 0));
    send_word({3'b111, bright, rgb});
  endtask

  task automatic send_led_overflow(input logic [4:0] bright, input logic [23:0] rgb);
    exp_q.push_back(mk(K_ERR, 0, 0, 0, 0));
    send_word({3'b111, bright, rgb});
  endtask

  task automatic send_end(input int count);
    exp_q.push_back(mk(K_DONE, 0, 0, 0, count));
    send_word(32'hFFFF_FFFF);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_led_valid"}, 32'(rec.led_valid), 0);
    check({tag, "_led_idx"}, 32'(rec.led_idx), 0);
    check({tag, "_led_bright"}, 32'(rec.led_bright), 0);
    check({tag, "_led_rgb"}, 32'(rec.led_rgb), 0);
    check({tag, "_frame_done"}, 32'(rec.frame_done), 0);
    check({tag, "_led_count"}, 32'(rec.led_count), 0);
    check({tag, "_frame_err"}, 32'(rec.frame_err), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 1: three LEDs, full brightness
    send_word(32'h0);
    send_led(0, 5'h1F, 24'h112233);
    send_led(1, 5'h1F, 24'h445566);
    send_led(2, 5'h1F, 24'h778899);
    send_end(3);
    drain();
    repeat (20) @(negedge clk);
    check("led_count_held", 32'(rec.led_count), 3);

    // 2: empty frame
    send_word(32'h0);
    send_end(0);
    drain();

    // 3: bad header aborts to HUNT, next frame is fine
    send_word(32'h0);
    exp_q.push_back(mk(K_ERR, 0, 0, 0, 0));
    send_word(32'h6000_0001);
    drain();
    send_word(32'h0);
    send_led(0, 5'h0A, 24'hABCDEF);
    send_end(1);
    drain();

    // 4: one word more than LEDS -> overflow error, count saturates
    send_word(32'h0);
    send_led(0, 5'h05, 24'h000001);
    send_led(1, 5'h10, 24'h800000);
    send_led(2, 5'h00, 24'hFFFFFF);
    send_led_overflow(5'h01, 24'h123456);
    send_end(3);
    drain();

    // 5: strip clock stops after 17 bits of an LED word -> timeout
    send_word(32'h0);
    exp_q.push_back(mk(K_ERR, 0, 0, 0, 0));
    send_bits({3'b111, 5'h1F, 24'h5A5A5A}, 17);
    repeat (TIMEOUT + 5) @(negedge clk);
    drain();
    send_word(32'h0);
    send_led(0, 5'h03, 24'h010203);
    send_led(1, 5'h04, 24'h040506);
    send_end(2);
    drain();

    // 6: reset mid-word, then a frame with a mid-stream restart
    send_word(32'h0);
    send_bits({3'b111, 5'h1F, 24'hC0FFEE}, 10);
    clkIn = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("midrst");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    send_word(32'h0);
    send_led(0, 5'h11, 24'h102030);
    send_led(1, 5'h12, 24'h405060);
    send_word(32'h0);
    send_led(0, 5'h13, 24'h708090);
    send_end(1);
    drain();
    repeat (10) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
